// File: rtl/systolic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_feed_ctrl
//
// Sequencing controller for the skew buffer bank in front of the systolic array.
// A tile-start command captures the tile length and lane mask. K vectors are
// then pulled from upstream over valid/ready and forwarded to the bank. After
// that, the longest skew line is flushed with zero vectors, and a one-cycle
// done pulse is raised.
//
// Optional feature: define FEED_CTRL_PERF_EN to build the LOAD-stall counter
// that drives stall_cnt. Without the macro, stall_cnt is a constant zero.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : tile-start request (only honoured in IDLE)
//   k_len      : vectors per tile, captured with start
//   lane_mask  : per-lane enable, captured with start
//   abort      : synchronous cancel, highest priority after reset
//   src_valid  : upstream vector available
//   src_data   : upstream vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready  : controller accepts a vector this cycle (LOAD state)
//   lane_valid : per-lane shift enable to the skew bank (registered)
//   lane_data  : per-lane data to the skew bank (registered)
//   busy       : high in every state except IDLE
//   done       : one-cycle tile-complete pulse
//   stall_cnt  : LOAD cycles with src_valid low (perf build only)
// -----------------------------------------------------------------------------
module systolic_feed_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUFFER_COUNT = 16,
    parameter int BUFFER_SIZE  = 27,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [LEN_WIDTH-1:0]             k_len,
    input  logic [BUFFER_COUNT-1:0]          lane_mask,
    input  logic                             abort,
    input  logic                             src_valid,
    input  logic [BUFFER_COUNT*DATA_WIDTH-1:0] src_data,
    output logic                             src_ready,
    output logic [BUFFER_COUNT-1:0]          lane_valid,
    output logic [BUFFER_COUNT*DATA_WIDTH-1:0] lane_data,
    output logic                             busy,
    output logic                             done,
    output logic [31:0]                      stall_cnt
);

    // The longest skew line (lane BUFFER_COUNT-1) needs this many zero
    // vectors to push the last real vector all the way through.
    localparam int DRAIN_LEN = BUFFER_SIZE + BUFFER_COUNT - 1;
    localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);
    localparam int VEC_W     = BUFFER_COUNT * DATA_WIDTH;

    localparam logic [DCNT_W-1:0]    DRAIN_LAST = DCNT_W'(DRAIN_LEN - 1);
    localparam logic [DCNT_W-1:0]    DCNT_ONE   = DCNT_W'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE    = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     k_len_q, k_len_d;
    logic [BUFFER_COUNT-1:0]  mask_q, mask_d;
    logic [LEN_WIDTH-1:0]     vec_cnt_q, vec_cnt_d;
    logic [DCNT_W-1:0]        drain_cnt_q, drain_cnt_d;
    logic [BUFFER_COUNT-1:0]  lane_valid_q, lane_valid_d;
    logic [VEC_W-1:0]         lane_data_q, lane_data_d;

    logic                     xfer;
    logic [VEC_W-1:0]         masked_data;

    // Disabled lanes are forced to zero so the array sees a clean operand.
    for (genvar gi = 0; gi < BUFFER_COUNT; gi++) begin : g_lane_mask
        assign masked_data[gi*DATA_WIDTH +: DATA_WIDTH] =
            mask_q[gi] ? src_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign src_ready  = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign xfer       = src_valid && src_ready;
    assign lane_valid = lane_valid_q;
    assign lane_data  = lane_data_q;

    always_comb begin
        state_d      = state_q;
        k_len_d      = k_len_q;
        mask_d       = mask_q;
        vec_cnt_d    = vec_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        lane_valid_d = '0;
        lane_data_d  = lane_data_q;

        if (abort) begin
            // A coincident transfer is consumed upstream (src_ready is high)
            // but deliberately not forwarded to the bank.
            state_d     = S_IDLE;
            vec_cnt_d   = '0;
            drain_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        k_len_d     = k_len;
                        mask_d      = lane_mask;
                        vec_cnt_d   = '0;
                        drain_cnt_d = '0;
                        state_d     = (k_len == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        lane_valid_d = '1;
                        lane_data_d  = masked_data;
                        if (vec_cnt_q == k_len_q - LEN_ONE) begin
                            state_d   = S_DRAIN;
                            vec_cnt_d = '0;
                        end else begin
                            vec_cnt_d = vec_cnt_q + LEN_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    lane_valid_d = '1;
                    lane_data_d  = '0;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = S_DONE;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DCNT_ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_len_q      <= '0;
            mask_q       <= '0;
            vec_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            lane_valid_q <= '0;
            lane_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            k_len_q      <= k_len_d;
            mask_q       <= mask_d;
            vec_cnt_q    <= vec_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            lane_valid_q <= lane_valid_d;
            lane_data_q  <= lane_data_d;
        end
    end

`ifdef FEED_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic        start_accept;

    assign start_accept = (state_q == S_IDLE) && start && !abort;

    // Saturating count of LOAD cycles where upstream had nothing to offer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (start_accept) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_LOAD) && !src_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_feed_ctrl
//
// Bench for systolic_feed_ctrl. The reference model tracks a tile in terms of
// "vectors still owed", "zero vectors still owed" and "done due now", and it
// is stepped on every rising edge. A compare process checks every DUT output
// against the model on each falling edge. Directed scenarios add literal
// expectations, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_systolic_feed_ctrl;

    localparam int DW        = 8;
    localparam int BC        = 16;
    localparam int BS        = 27;
    localparam int LW        = 16;
    localparam int VW        = BC * DW;
    localparam int DRAIN_LEN = BS + BC - 1;

    localparam logic [VW-1:0] PAT2 = 128'h0000_0000_0000_0000_AAAA_AAAA_AAAA_AAAA;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [LW-1:0]  k_len;
    logic [BC-1:0]  lane_mask;
    logic           abort;
    logic           src_valid;
    logic [VW-1:0]  src_data;
    logic           src_ready;
    logic [BC-1:0]  lane_valid;
    logic [VW-1:0]  lane_data;
    logic           busy;
    logic           done;
    logic [31:0]    stall_cnt;

    systolic_feed_ctrl #(
        .DATA_WIDTH   (DW),
        .BUFFER_COUNT (BC),
        .BUFFER_SIZE  (BS),
        .LEN_WIDTH    (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_len      (k_len),
        .lane_mask  (lane_mask),
        .abort      (abort),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .busy       (busy),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] apply_mask(input logic [VW-1:0] d, input logic [BC-1:0] m);
        logic [VW-1:0] r;
        r = d;
        for (int i = 0; i < BC; i++) begin
            if (!m[i]) r[i*DW +: DW] = '0;
        end
        return r;
    endfunction

    // ---------------- reference model ----------------
    int             m_remaining = 0;   // vectors still to be accepted
    int             m_drain_left = 0;  // zero vectors still to be emitted
    bit             m_done_now = 0;    // done is due in the current cycle
    bit             m_init = 0;
    logic [BC-1:0]  m_mask = '0;
    logic [BC-1:0]  m_lv = '0;
    logic [VW-1:0]  m_ld = '0;
    logic [31:0]    m_stall = '0;

    initial begin
        forever begin
            bit idle;
            bit ready;
            @(posedge clk);
            idle  = (m_remaining == 0) && (m_drain_left == 0) && !m_done_now;
            ready = (m_remaining > 0);
            if (!rst_n) begin
                m_remaining  = 0;
                m_drain_left = 0;
                m_done_now   = 0;
                m_lv         = '0;
                m_ld         = '0;
                m_stall      = '0;
                m_init       = 1;
            end else begin
                if (ready && !src_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                m_lv = '0;
                if (abort) begin
                    m_remaining  = 0;
                    m_drain_left = 0;
                    m_done_now   = 0;
                end else if (idle) begin
                    if (start) begin
                        m_stall = '0;
                        m_mask  = lane_mask;
                        if (k_len == 0) m_done_now = 1;
                        else            m_remaining = int'(k_len);
                    end
                end else if (ready) begin
                    if (src_valid) begin
                        m_lv = '1;
                        m_ld = apply_mask(src_data, m_mask);
                        m_remaining--;
                        if (m_remaining == 0) m_drain_left = DRAIN_LEN;
                    end
                end else if (m_drain_left > 0) begin
                    m_lv = '1;
                    m_ld = '0;
                    m_drain_left--;
                    if (m_drain_left == 0) m_done_now = 1;
                end else begin
                    m_done_now = 0;
                end
            end
        end
    end

    // ---------------- compare process + observation stats ----------------
    int negcyc = 0;
    int xfer_cnt, first_xfer, last_xfer, run_len, max_run, done_cnt, last_done, pat2_hits, acc_neg;

    task automatic clear_stats();
        xfer_cnt   = 0;
        first_xfer = -1;
        last_xfer  = -1;
        run_len    = 0;
        max_run    = 0;
        done_cnt   = 0;
        last_done  = -1;
        pat2_hits  = 0;
        acc_neg    = -1;
    endtask

    initial begin
        clear_stats();
        forever begin
            logic [31:0] exp_stall;
            @(negedge clk);
            negcyc++;
            if (m_init) begin
`ifdef FEED_CTRL_PERF_EN
                exp_stall = m_stall;
`else
                exp_stall = '0;
`endif
                chk("src_ready",  VW'(src_ready),  VW'(m_remaining > 0));
                chk("busy",       VW'(busy),       VW'(m_remaining > 0 || m_drain_left > 0 || m_done_now));
                chk("done",       VW'(done),       VW'(m_done_now));
                chk("lane_valid", VW'(lane_valid), VW'(m_lv));
                chk("lane_data",  lane_data,       m_ld);
                chk("stall_cnt",  VW'(stall_cnt),  VW'(exp_stall));
            end
            if (src_ready === 1'b1 && src_valid) begin
                xfer_cnt++;
                if (first_xfer < 0) first_xfer = negcyc;
                last_xfer = negcyc;
            end
            if (lane_valid === '1) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (lane_data === PAT2) pat2_hits++;
            end else begin
                run_len = 0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done = negcyc;
                $display("tile done at cycle %0d", negcyc);
            end
            if (start && rst_n && !abort && busy === 1'b0) acc_neg = negcyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        lane_mask = '1;
        abort     = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        @(posedge clk);
        #2;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_busy", VW'(busy), '0);
        chk("rst_lane_valid", VW'(lane_valid), '0);
        chk("rst_lane_data", lane_data, '0);
        chk("rst_src_ready", VW'(src_ready), '0);

        // 1: k_len=4, all lanes, src_valid always high
        clear_stats();
        start = 1'b1; k_len = 16'd4; lane_mask = '1; src_valid = 1'b1; src_data = rand_vec();
        cycle();
        start = 1'b0;
        repeat (60) begin
            src_data = rand_vec();
            cycle();
        end
        chk("t1_xfers", VW'(xfer_cnt), VW'(4));
        chk("t1_xfer_span", VW'(last_xfer - first_xfer), VW'(3));
        chk("t1_valid_run", VW'(max_run), VW'(46));
        chk("t1_done_cnt", VW'(done_cnt), VW'(1));
        chk("t1_done_lat", VW'(last_done - last_xfer), VW'(43));
        src_valid = 1'b0;
        cycle();

        // 2: lane mask 0x00FF, data 0xAA
        clear_stats();
        start = 1'b1; k_len = 16'd3; lane_mask = 16'h00FF; src_valid = 1'b1; src_data = {BC{8'hAA}};
        cycle();
        start = 1'b0;
        repeat (50) cycle();
        chk("t2_masked_vecs", VW'(pat2_hits), VW'(3));
        chk("t2_done_cnt", VW'(done_cnt), VW'(1));
        src_valid = 1'b0;
        cycle();

        // 3: k_len=5, src_valid toggling 1,0,1,0...
        clear_stats();
        start = 1'b1; k_len = 16'd5; lane_mask = '1; src_valid = 1'b0;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            src_valid = (i % 2 == 0) && (i < 10);
            src_data  = rand_vec();
            cycle();
        end
        chk("t3_xfers", VW'(xfer_cnt), VW'(5));
        chk("t3_xfer_span", VW'(last_xfer - first_xfer), VW'(8));
`ifdef FEED_CTRL_PERF_EN
        chk("t3_stall", VW'(stall_cnt), VW'(4));
`else
        chk("t3_stall", VW'(stall_cnt), VW'(0));
`endif

        // 4: k_len=0 goes straight to DONE
        clear_stats();
        start = 1'b1; k_len = 16'd0; src_valid = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        chk("t4_done_cnt", VW'(done_cnt), VW'(1));
        chk("t4_done_lat", VW'(last_done - acc_neg), VW'(1));
        chk("t4_no_valid", VW'(max_run), VW'(0));
        chk("t4_no_xfer", VW'(xfer_cnt), VW'(0));
        src_valid = 1'b0;
        cycle();

        // 5: abort on the 10th DRAIN cycle, then a fresh tile
        clear_stats();
        start = 1'b1; k_len = 16'd2; src_valid = 1'b1; src_data = rand_vec();
        cycle();
        start = 1'b0;
        repeat (11) cycle();
        chk("t5_in_drain", VW'(lane_valid), VW'({BC{1'b1}}));
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        src_valid = 1'b0;
        chk("t5_abort_busy", VW'(busy), '0);
        chk("t5_abort_lv", VW'(lane_valid), '0);
        repeat (50) cycle();
        chk("t5_no_done", VW'(done_cnt), VW'(0));
        start = 1'b1; k_len = 16'd1; src_valid = 1'b1;
        cycle();
        start = 1'b0;
        repeat (50) cycle();
        chk("t5_restart_done", VW'(done_cnt), VW'(1));
        chk("t5_restart_xfer", VW'(xfer_cnt), VW'(3));
        src_valid = 1'b0;
        cycle();

        // 6: reset pulse mid-LOAD with start held during reset
        start = 1'b1; k_len = 16'd6; src_valid = 1'b0;
        cycle();
        start = 1'b0;
        cycle();
        chk("t6_in_load", VW'(src_ready), VW'(1));
        rst_n = 1'b0; start = 1'b1;
        cycle();
        rst_n = 1'b1; start = 1'b0;
        chk("t6_rst_busy", VW'(busy), '0);
        chk("t6_rst_ready", VW'(src_ready), '0);
        chk("t6_rst_lv", VW'(lane_valid), '0);
        chk("t6_rst_ld", lane_data, '0);
        chk("t6_rst_stall", VW'(stall_cnt), '0);
        cycle();
        chk("t6_start_ignored", VW'(busy), '0);

        // 7: randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            k_len     = LW'($urandom_range(0, 6));
            lane_mask = BC'($urandom);
            abort     = ($urandom_range(0, 79) == 0);
            src_valid = ($urandom_range(0, 3) != 0);
            src_data  = rand_vec();
            rst_n     = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
